// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_pkg
// Description : Shared definitions for the req/ack clock-domain-crossing
//               handshake: sender FSM state encoding and the legal range of
//               the acknowledge synchronizer depth.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_pkg;

    // Sender FSM state encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_REQ_HI = 2'd1;
    localparam logic [1:0] c_ST_ACK_LO = 2'd2;

    // Legal synchronizer depth range
    localparam int c_SYNC_STAGE_MIN = 2;
    localparam int c_SYNC_STAGE_MAX = 8;

    // Forces a requested synchronizer depth into the legal range so an
    // out-of-range parameter still builds a working chain.
    function automatic int clamp_sync_stages(input int n);
        if (n < c_SYNC_STAGE_MIN) begin
            return c_SYNC_STAGE_MIN;
        end
        if (n > c_SYNC_STAGE_MAX) begin
            return c_SYNC_STAGE_MAX;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : cdc_sync_bit
// Description : Single-bit multi-flop synchronizer. Brings an asynchronous
//               level into the clk domain through SYNC_STAGE_NUM flops.
// Ports       : clk  - destination clock
//               rst  - synchronous active-high reset, clears the chain to 0
//               i_d  - asynchronous input level
//               o_q  - synchronized level (last flop of the chain)
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_sync_bit #(
    parameter int SYNC_STAGE_NUM = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGE_NUM-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGE_NUM-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGE_NUM-1];

endmodule
`default_nettype wire

// File: rtl/cdc_hs_sender.sv
`default_nettype none
// ============================================================================
// Module      : cdc_hs_sender
// Description : Source-domain end of a 4-phase req/ack CDC handshake. Accepts
//               one word on a valid/ready interface, holds it on cdc_data_o,
//               raises cdc_req_o and walks the 4-phase cycle using a
//               synchronized copy of cdc_ack_i.
// Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//               src_valid_i/src_data_i/src_ready_o - source word interface
//               cdc_req_o, cdc_data_o - registered request and held word
//               cdc_ack_i             - asynchronous acknowledge
//               done_o                - one-cycle pulse per completed transfer
//               busy_o                - high whenever not IDLE
//               timeout_o             - one-cycle timeout pulse (option only)
// Options     : CDC_HS_TIMEOUT_EN - adds a per-wait-state timeout counter
//               and the timeout_o port.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_hs_sender
    import cdc_pkg::*;
#(
    parameter int DLY            = 0,
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGE_NUM = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  src_valid_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    output logic                  src_ready_o,
    output logic                  cdc_req_o,
    output logic [DATA_WIDTH-1:0] cdc_data_o,
    input  logic                  cdc_ack_i,
    output logic                  done_o,
`ifdef CDC_HS_TIMEOUT_EN
    output logic                  busy_o,
    output logic                  timeout_o
`else
    output logic                  busy_o
`endif
);

    localparam int c_SYNC_STAGES = clamp_sync_stages(SYNC_STAGE_NUM);

    // DLY is a simulation-only clock-to-q figure and has no synthesizable
    // counterpart; TIMEOUT_CYCLES only matters with the timeout option. Both
    // are referenced here so every build elaborates them; the block is empty.
    if (DLY < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    end

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_req;
    logic                  w_req_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_ack_s;

    // Raw cdc_ack_i goes nowhere except into this chain.
    cdc_sync_bit #(
        .SYNC_STAGE_NUM (c_SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk_i),
        .rst (rst_i),
        .i_d (cdc_ack_i),
        .o_q (w_ack_s)
    );

`ifdef CDC_HS_TIMEOUT_EN
    localparam int              c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout;
    logic              w_timeout_nxt;
    logic              r_abort;
    logic              w_abort_nxt;
    logic              w_to_hit;

    // Counter reads TIMEOUT_CYCLES-1 on the last cycle of the window, so the
    // registered timeout lands TIMEOUT_CYCLES edges after entering the state.
    assign w_to_hit = (r_to_cnt == c_TO_LAST);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
        w_timeout_nxt = 1'b0;
        w_abort_nxt   = r_abort;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (src_valid_i && src_ready_o) begin
                    w_data_nxt  = src_data_i;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = c_ST_REQ_HI;
                end
            end
            c_ST_REQ_HI: begin
                if (w_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = c_ST_ACK_LO;
                end
`ifdef CDC_HS_TIMEOUT_EN
                else if (w_to_hit) begin
                    w_req_nxt     = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_abort_nxt   = 1'b1;
                    w_state_nxt   = c_ST_ACK_LO;
                end
`endif
            end
            c_ST_ACK_LO: begin
`ifdef CDC_HS_TIMEOUT_EN
                // An abandoned request gives the destination the full window
                // to finish any late ack cycle, and never reports done.
                if (!w_ack_s && !r_abort) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (w_to_hit) begin
                    w_timeout_nxt = 1'b1;
                    w_abort_nxt   = 1'b0;
                    w_state_nxt   = c_ST_IDLE;
                end
`else
                if (!w_ack_s) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
`endif
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef CDC_HS_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
            r_abort   <= w_abort_nxt;
            if ((w_state_nxt != r_state) || (r_state == c_ST_IDLE)) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`endif

    assign src_ready_o = (r_state == c_ST_IDLE);
    assign busy_o      = (r_state != c_ST_IDLE);
    assign cdc_req_o   = r_req;
    assign cdc_data_o  = r_data;
    assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cdc_hs_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_hs_sender
// Description : Directed and randomized self-checking bench for
//               cdc_hs_sender with a behavioural 4-phase destination model.
// Options     : CDC_HS_TIMEOUT_EN - also exercises the timeout path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_hs_sender;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       src_valid_i;
    logic [7:0] src_data_i;
    logic       src_ready_o;
    logic       cdc_req_o;
    logic [7:0] cdc_data_o;
    logic       cdc_ack_i;
    logic       done_o;
    logic       busy_o;
`ifdef CDC_HS_TIMEOUT_EN
    logic       timeout_o;
`endif

    int checks = 0;
    int errors = 0;

    // destination model controls (written by the main sequence only)
    bit dest_en  = 1'b0;
    bit man_ack  = 1'b0;
    bit rand_dly = 1'b0;
    int rise_cfg = 3;
    int fall_cfg = 3;
    int off_max  = 0;
    bit mon_en   = 1'b1;

    // written by the model / monitor only
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int done_cnt  = 0;
    int prot_seen = 0;
    int prot_bad  = 0;

    always #5 clk_i = ~clk_i;

    cdc_hs_sender #(
        .DLY            (0),
        .DATA_WIDTH     (8),
        .SYNC_STAGE_NUM (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .src_valid_i (src_valid_i),
        .src_data_i  (src_data_i),
        .src_ready_o (src_ready_o),
        .cdc_req_o   (cdc_req_o),
        .cdc_data_o  (cdc_data_o),
        .cdc_ack_i   (cdc_ack_i),
        .done_o      (done_o),
`ifdef CDC_HS_TIMEOUT_EN
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
`else
        .busy_o      (busy_o)
`endif
    );

    // Destination side: captures the word when it first sees req, raises ack
    // after a delay, drops it after req falls. Edges land 2..9 units after a
    // clock edge, i.e. at arbitrary sub-cycle points.
    initial begin : dest_model
        int k;
        int rd;
        int fd;
        cdc_ack_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            if (!dest_en) begin
                cdc_ack_i = man_ack;
            end else if (cdc_req_o && !cdc_ack_i) begin
                rx_q.push_back(cdc_data_o);
                rd = rand_dly ? $urandom_range(0, 3) : rise_cfg;
                fd = rand_dly ? $urandom_range(0, 3) : fall_cfg;
                repeat (rd) @(posedge clk_i);
                #(2 + $urandom_range(0, off_max));
                cdc_ack_i = 1'b1;
                k = 0;
                while (cdc_req_o && k < 300) begin
                    @(posedge clk_i);
                    #2;
                    k++;
                end
                repeat (fd) @(posedge clk_i);
                #(2 + $urandom_range(0, off_max));
                cdc_ack_i = 1'b0;
            end
        end
    end

    // Records done pulses and 4-phase legality: req may rise only with ack
    // low and may fall only with ack high.
    initial begin : protocol_monitor
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (done_o === 1'b1) done_cnt++;
            if (mon_en && (cdc_req_o !== req_prev)) begin
                prot_seen++;
                if (cdc_req_o === cdc_ack_i) prot_bad++;
            end
            req_prev = cdc_req_o;
        end
    end

    // Presents w until accepted; while the block is busy the bus carries ~w
    // so an unintended capture would be visible.
    task automatic send_word(input logic [7:0] w, output bit ok);
        int n;
        n = 0;
        @(negedge clk_i);
        src_valid_i = 1'b1;
        while (!src_ready_o && n < 500) begin
            src_data_i = ~w;
            @(negedge clk_i);
            n++;
        end
        src_data_i = w;
        ok = (n < 500);
        @(posedge clk_i);
        tx_q.push_back(w);
        #1;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; src_valid_i = 1'b0; src_data_i = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (cdc_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, expected 0", cdc_req_o); end
        checks++; if (cdc_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, expected 00", cdc_data_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
`ifdef CDC_HS_TIMEOUT_EN
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, expected 0", timeout_o); end
`endif
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++; if (src_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b, expected 1", src_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b, expected 0", busy_o); end
    endtask

    task automatic test_basic();
        bit ok;
        int rb, fall_k, done_k, done_n;
        bit data_bad;
        logic rdy_after, done_after;
        dest_en = 1'b1; rand_dly = 1'b0; rise_cfg = 3; fall_cfg = 3; off_max = 0;
        rb = rx_q.size();
        fall_k = -1; done_k = -1; done_n = 0; data_bad = 1'b0;
        rdy_after = 1'bx; done_after = 1'bx;
        send_word(8'hA5, ok);
        src_valid_i = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL basic_accept: accepted=0, expected 1"); end
        checks++; if (cdc_req_o !== 1'b1) begin errors++; $display("FAIL basic_req_rise: got %b, expected 1", cdc_req_o); end
        checks++; if (cdc_data_o !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h, expected a5", cdc_data_o); end
        checks++; if (src_ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_busy: got %b, expected 0", src_ready_o); end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_i);
            #1;
            if (cdc_req_o === 1'b0 && fall_k < 0) fall_k = k;
            if (cdc_data_o !== 8'hA5) data_bad = 1'b1;
            if (done_o === 1'b1) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (done_k > 0 && k == done_k + 1) begin
                rdy_after  = src_ready_o;
                done_after = done_o;
            end
        end
        // ack seen at +4, 3 sync flops, FSM edge: req falls 7 edges after accept;
        // ack drops 3 edges later, +4 more for done.
        checks++; if (fall_k !== 7) begin errors++; $display("FAIL basic_req_fall_cycle: got %0d, expected 7", fall_k); end
        checks++; if (done_k !== 14) begin errors++; $display("FAIL basic_done_cycle: got %0d, expected 14", done_k); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL basic_done_count: got %0d, expected 1", done_n); end
        checks++; if (data_bad !== 1'b0) begin errors++; $display("FAIL basic_data_stable: changed=%b, expected 0", data_bad); end
        checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL basic_ready_return: got %b, expected 1", rdy_after); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b, expected 0", done_after); end
        checks++;
        if (rx_q.size() != rb + 1) begin errors++; $display("FAIL basic_rx_count: got %0d, expected 1", rx_q.size() - rb); end
        else if (rx_q[rb] !== 8'hA5) begin errors++; $display("FAIL basic_rx_word: got %h, expected a5", rx_q[rb]); end
    endtask

    task automatic test_latency();
        bit ok;
        int fall_k, done_k;
        dest_en = 1'b0; man_ack = 1'b0;
        fall_k = -1; done_k = -1;
        send_word(8'h5A, ok);
        src_valid_i = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL lat_accept: accepted=0, expected 1"); end
        repeat (2) @(posedge clk_i);
        #1;
        man_ack = 1'b1;                        // ack rises just after edge T
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk_i);
            #1;
            if (cdc_req_o === 1'b0 && fall_k < 0) fall_k = k;
        end
        checks++; if (fall_k !== 4) begin errors++; $display("FAIL lat_req_fall: got T+%0d, expected T+4", fall_k); end
        man_ack = 1'b0;                        // ack falls just after edge T'
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk_i);
            #1;
            if (done_o === 1'b1 && done_k < 0) done_k = k;
        end
        checks++; if (done_k !== 4) begin errors++; $display("FAIL lat_done: got T'+%0d, expected T'+4", done_k); end
        checks++; if (cdc_data_o !== 8'h5A) begin errors++; $display("FAIL lat_data_hold: got %h, expected 5a", cdc_data_o); end
    endtask

    task automatic test_back_to_back();
        bit ok, all_ok;
        int rb, db, cyc;
        logic [7:0] words[3];
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        dest_en = 1'b1; rand_dly = 1'b0; rise_cfg = 1; fall_cfg = 1; off_max = 0;
        rb = rx_q.size(); db = done_cnt; all_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_word(words[i], ok);
            all_ok &= ok;
        end
        src_valid_i = 1'b0;
        wait_done(100, cyc);
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (!all_ok || cyc < 0) begin errors++; $display("FAIL b2b_progress: accepted=%b done_seen=%0d, expected 1/positive", all_ok, cyc); end
        checks++; if (done_cnt - db !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d, expected 3", done_cnt - db); end
        checks++; if (rx_q.size() - rb !== 3) begin errors++; $display("FAIL b2b_rx_count: got %0d, expected 3", rx_q.size() - rb); end
        for (int i = 0; i < 3; i++) begin
            if (rb + i < rx_q.size()) begin
                checks++;
                if (rx_q[rb + i] !== words[i]) begin errors++; $display("FAIL b2b_word%0d: got %h, expected %h", i, rx_q[rb + i], words[i]); end
            end
        end
        checks++; if (cdc_data_o !== 8'h03) begin errors++; $display("FAIL b2b_idle_hold: got %h, expected 03", cdc_data_o); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int rb, cyc;
        dest_en = 1'b0; man_ack = 1'b0; mon_en = 1'b0;
        send_word(8'h77, ok);
        src_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++; if (busy_o !== 1'b1 || cdc_req_o !== 1'b1) begin errors++; $display("FAIL rmid_in_req_hi: busy=%b req=%b, expected 1/1", busy_o, cdc_req_o); end
        rst_i = 1'b1; src_valid_i = 1'b1; src_data_i = 8'hEE;
        @(posedge clk_i);
        #1;
        checks++; if (cdc_req_o !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b, expected 0", cdc_req_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, expected 0", busy_o); end
        checks++; if (cdc_data_o !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h, expected 00", cdc_data_o); end
        @(posedge clk_i);
        #1;
        checks++; if (cdc_req_o !== 1'b0 || cdc_data_o !== 8'h00) begin errors++; $display("FAIL rmid_reset_wins: req=%b data=%h, expected 0/00", cdc_req_o, cdc_data_o); end
        rst_i = 1'b0; src_valid_i = 1'b0;
        @(posedge clk_i);
        dest_en = 1'b1; rand_dly = 1'b0; rise_cfg = 2; fall_cfg = 2; off_max = 0;
        rb = rx_q.size();
        send_word(8'h3C, ok);
        src_valid_i = 1'b0;
        wait_done(100, cyc);
        checks++; if (!ok || cyc < 0) begin errors++; $display("FAIL rmid_next_done: accepted=%b done_at=%0d, expected 1/positive", ok, cyc); end
        checks++;
        if (rx_q.size() != rb + 1) begin errors++; $display("FAIL rmid_rx_count: got %0d, expected 1", rx_q.size() - rb); end
        else if (rx_q[rb] !== 8'h3C) begin errors++; $display("FAIL rmid_rx_word: got %h, expected 3c", rx_q[rb]); end
        repeat (2) @(posedge clk_i);
        mon_en = 1'b1;
    endtask

    task automatic test_random();
        bit ok, all_ok;
        int rb, tb0, db, cyc, n;
        logic [7:0] w;
        n = 500;
        dest_en = 1'b1; rand_dly = 1'b1; off_max = 5;
        rb = rx_q.size(); tb0 = tx_q.size(); db = done_cnt; all_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
            w = 8'($urandom_range(0, 255));
            send_word(w, ok);
            all_ok &= ok;
            if ($urandom_range(0, 1) == 0) src_valid_i = 1'b0;
        end
        src_valid_i = 1'b0;
        wait_done(200, cyc);
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (!all_ok || cyc < 0) begin errors++; $display("FAIL rand_progress: accepted=%b done_at=%0d, expected 1/positive", all_ok, cyc); end
        checks++; if (done_cnt - db !== n) begin errors++; $display("FAIL rand_done_count: got %0d, expected %0d", done_cnt - db, n); end
        checks++; if (rx_q.size() - rb !== n) begin errors++; $display("FAIL rand_rx_count: got %0d, expected %0d", rx_q.size() - rb, n); end
        for (int i = 0; i < n; i++) begin
            if (rb + i < rx_q.size()) begin
                checks++;
                if (rx_q[rb + i] !== tx_q[tb0 + i]) begin errors++; $display("FAIL rand_word%0d: got %h, expected %h", i, rx_q[rb + i], tx_q[tb0 + i]); end
            end
        end
        checks++; if (prot_seen == 0) begin errors++; $display("FAIL protocol_activity: req edges %0d, expected nonzero", prot_seen); end
        checks++; if (prot_bad !== 0) begin errors++; $display("FAIL protocol_4phase: illegal edges %0d, expected 0", prot_bad); end
        rand_dly = 1'b0; off_max = 0;
    endtask

`ifdef CDC_HS_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int to1, to2, done_n;
        logic req_at1, rdy_at2;
        dest_en = 1'b0; man_ack = 1'b0; mon_en = 1'b0;
        to1 = -1; to2 = -1; done_n = 0; req_at1 = 1'bx; rdy_at2 = 1'bx;
        send_word(8'hC3, ok);
        src_valid_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i);
            #1;
            if (done_o === 1'b1) done_n++;
            if (timeout_o === 1'b1) begin
                if (to1 < 0) begin
                    to1 = k; req_at1 = cdc_req_o;
                end else if (to2 < 0) begin
                    to2 = k; rdy_at2 = src_ready_o;
                end
            end
        end
        checks++; if (to1 !== 16) begin errors++; $display("FAIL to_first: got %0d, expected 16", to1); end
        checks++; if (req_at1 !== 1'b0) begin errors++; $display("FAIL to_req_drop: got %b, expected 0", req_at1); end
        checks++; if (to2 !== 32) begin errors++; $display("FAIL to_second: got %0d, expected 32", to2); end
        checks++; if (rdy_at2 !== 1'b1) begin errors++; $display("FAIL to_idle: ready=%b, expected 1", rdy_at2); end
        checks++; if (done_n !== 0) begin errors++; $display("FAIL to_no_done: got %0d, expected 0", done_n); end
        mon_en = 1'b1;
    endtask
`endif

    initial begin
        rst_i = 1'b1; src_valid_i = 1'b0; src_data_i = 8'h00;
        test_reset();
        test_basic();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef CDC_HS_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
